seq_booth_multiplier: RTL and testbench

SEQ_BOOTH_MULTIPLIER -- requirements
Module: seq_booth_multiplier

---
 rtl/seq_booth_multiplier.sv | 104 ++++++++++
 tb/tb_seq_booth_multiplier.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock on a 65-bit
// product register, low 32 bits of the signed product plus an overflow flag.
module seq_booth_multiplier (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg, count_next;
  logic [31:0] mcand_reg, mcand_next;
  logic [64:0] prod_reg, prod_next;
  logic [31:0] result_reg, result_next;
  logic        exc_reg, exc_next;
  logic        rdy_reg, rdy_next;

  logic [32:0] hi_ext;
  logic [32:0] addend;
  logic        cin;
  logic [32:0] sum;
  logic [64:0] step_prod;

  // Sign-extending to 33 bits keeps the true sign of the sum, which becomes
  // the shift-in bit; this is what makes a 0x80000000 multiplicand safe.
  always_comb begin
    hi_ext = {prod_reg[64], prod_reg[64:33]};
    addend = '0;
    cin    = 1'b0;
    case (prod_reg[1:0])
      2'b01: addend = {mcand_reg[31], mcand_reg};
      2'b10: begin
        addend = ~{mcand_reg[31], mcand_reg};
        cin    = 1'b1;
      end
      default: addend = '0;
    endcase
    sum       = hi_ext + addend + {32'b0, cin};
    step_prod = {sum[32], sum[31:0], prod_reg[32:1]};
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    mcand_next  = mcand_reg;
    prod_next   = prod_reg;
    result_next = result_reg;
    exc_next    = exc_reg;
    rdy_next    = 1'b0;
    if (ctrl_MULT) begin
      // A start in any state restarts; an operation in flight is dropped.
      mcand_next = data_operandA;
      prod_next  = {32'b0, data_operandB, 1'b0};
      count_next = 5'd0;
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN: begin
          prod_next  = step_prod;
          count_next = count_reg + 5'd1;
          if (count_reg == 5'd31) begin
            state_next  = DONE;
            rdy_next    = 1'b1;
            result_next = step_prod[32:1];
            exc_next    = (step_prod[64:33] != {32{step_prod[32]}});
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= 5'd0;
      mcand_reg  <= 32'd0;
      prod_reg   <= 65'd0;
      result_reg <= 32'd0;
      exc_reg    <= 1'b0;
      rdy_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      mcand_reg  <= mcand_next;
      prod_reg   <= prod_next;
      result_reg <= result_next;
      exc_reg    <= exc_next;
      rdy_reg    <= rdy_next;
    end
  end

  assign data_result    = result_reg;
  assign data_exception = exc_reg;
  assign data_resultRDY = rdy_reg;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Scoreboard bench for seq_booth_multiplier: directed operand pairs with
// hand-computed products; a negedge monitor checks value, flag and timing.
module tb_seq_booth_multiplier;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  seq_booth_multiplier dut (
    .clock         (clock),
    .reset         (reset),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Capture happens on the next rising edge; the strobe is then visible
  // at the falling edge 33 posedges after this point.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic exc, input bit push);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    if (push) sb.push_back('{res, exc, cyc + 33});
    tick();
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clock) begin
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        check("unexpected_rdy", {31'b0, data_resultRDY}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rdy_cycle", 32'(cyc), 32'(mon_e.due));
        check("result", data_result, mon_e.res);
        check("exception", {31'b0, data_exception}, {31'b0, mon_e.exc});
        $display("txn cycle=%0d result=0x%08h exception=%0d", cyc, data_result, data_exception);
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      check("rdy_timeout", 32'(cyc), 32'(sb[0].due));
      void'(sb.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_result", data_result, 32'd0);
    check("reset_exception", {31'b0, data_exception}, 32'd0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);

    issue(32'd3, 32'd4, 32'h0000000C, 1'b0, 1'b1);
    drain();

    issue(32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_result", data_result, 32'hFFFFFFD6);
      check("hold_exception", {31'b0, data_exception}, 32'd0);
    end

    issue(32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 1'b1);
    drain();
    issue(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1);
    drain();
    issue(32'h80000000, 32'd1, 32'h80000000, 1'b0, 1'b1);
    drain();
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
    drain();
    issue(32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b1);
    drain();
    issue(32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b1);
    drain();
    issue(32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1);
    drain();

    // Restart while the DONE strobe is up: both results must appear.
    issue(32'h00001234, 32'h00000010, 32'h00012340, 1'b0, 1'b1);
    repeat (32) tick();
    issue(32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0000000F, 1'b0, 1'b1);
    drain();

    // Abort in RUN: only the second operation may complete.
    issue(32'd5, 32'd5, 32'd25, 1'b0, 1'b0);
    repeat (9) tick();
    issue(32'd2, 32'd9, 32'h00000012, 1'b0, 1'b1);
    drain();
    repeat (5) tick();

    // Reset mid-operation, then start immediately after release.
    issue(32'd100, 32'd100, 32'd10000, 1'b0, 1'b0);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_result", data_result, 32'd0);
    check("midreset_exception", {31'b0, data_exception}, 32'd0);
    check("midreset_rdy", {31'b0, data_resultRDY}, 32'd0);
    issue(32'd6, 32'd7, 32'h0000002A, 1'b0, 1'b1);
    drain();
    repeat (5) tick();

    // Reset wins over a simultaneous start.
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    tick();
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    check("resetstart_result", data_result, 32'd0);
    for (int i = 0; i < 40; i++) begin
      check("resetstart_rdy", {31'b0, data_resultRDY}, 32'd0);
      tick();
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
